// File: rtl/cpu_pkg.sv
// Shared constants and small types for the 16-bit pipelined processor decode stage.
package cpu_pkg;

    // Datapath, register index and raw immediate widths
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int IMM_W    = 8;
    localparam int NUM_REGS = 2 ** ADDR_W;

    // Architecturally special registers: R0 is hardwired zero, R7 holds the link address
    localparam logic [ADDR_W-1:0] REG_ZERO = 3'd0;
    localparam logic [ADDR_W-1:0] REG_LINK = 3'd7;

    // Where the raw immediate lands inside the extended word
    typedef enum logic {
        PLACE_LOW  = 1'b0,
        PLACE_HIGH = 1'b1
    } ext_place_e;

    // Signed three-way compare result; exactly one flag is set
    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

endpackage

// File: rtl/op_regfile.sv
// 8x16 register file: synchronous active-low clear, one write port, two combinational
// read ports and a dedicated tap on the link register.
module op_regfile
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    input  logic [ADDR_W-1:0] rw,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_link
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Clear every register on reset; otherwise commit the WB write, never touching R0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (rw != REG_ZERO)) begin
            regs[rw] <= wdata;
        end
    end

    // Reads see the array as it stands; a same-cycle write is covered by external forwarding
    always_comb begin
        rdata_a    = regs[ra];
        rdata_b    = regs[rb];
        rdata_link = regs[REG_LINK];
    end

endmodule

// File: rtl/id_operand_core.sv
// Decode-stage operand core: register file, immediate extender and signed comparator
// used for branch resolution on forwarded operands.
module id_operand_core
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW,
    input  logic              enableWrite,
    input  logic [DATA_W-1:0] BusW,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB,
    output logic [DATA_W-1:0] R7,
    input  logic [IMM_W-1:0]  imm_in,
    input  logic              ExtOp,
    input  logic              ExtPlace,
    output logic [DATA_W-1:0] ext_out,
    input  logic [DATA_W-1:0] cmp_a,
    input  logic [DATA_W-1:0] cmp_b,
    output logic              gt,
    output logic              lt,
    output logic              eq
);

    localparam int PAD_W = DATA_W - IMM_W;

    ext_place_e place;
    cmp_flags_t flags;

    op_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra         (RA),
        .rb         (RB),
        .rw         (RW),
        .we         (enableWrite),
        .wdata      (BusW),
        .rdata_a    (BusA),
        .rdata_b    (BusB),
        .rdata_link (R7)
    );

    assign place = ext_place_e'(ExtPlace);

    // Low placement sign- or zero-extends; high placement shifts the byte up for LUI-style loads
    always_comb begin
        ext_out = '0;
        case (place)
            PLACE_HIGH: ext_out = {imm_in, {PAD_W{1'b0}}};
            default:    ext_out = {{PAD_W{ExtOp & imm_in[IMM_W-1]}}, imm_in};
        endcase
    end

    // Two's-complement compare; gt is derived so the three flags are always mutually exclusive
    always_comb begin
        flags    = '0;
        flags.eq = (cmp_a == cmp_b);
        flags.lt = ($signed(cmp_a) < $signed(cmp_b));
        flags.gt = !flags.eq && !flags.lt;
    end

    assign gt = flags.gt;
    assign lt = flags.lt;
    assign eq = flags.eq;

endmodule

// File: tb/tb_id_operand_core.sv
// Randomized self-checking bench for id_operand_core against a behavioural model.
module tb_id_operand_core;

    logic        clk;
    logic        rst_n;
    logic [2:0]  RA, RB, RW;
    logic        enableWrite;
    logic [15:0] BusW, BusA, BusB, R7;
    logic [7:0]  imm_in;
    logic        ExtOp, ExtPlace;
    logic [15:0] ext_out;
    logic [15:0] cmp_a, cmp_b;
    logic        gt, lt, eq;

    int n_vectors;
    int n_miscompares;

    // Behavioural register contents, plain integers per index
    int model_regs [8];

    id_operand_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RA          (RA),
        .RB          (RB),
        .RW          (RW),
        .enableWrite (enableWrite),
        .BusW        (BusW),
        .BusA        (BusA),
        .BusB        (BusB),
        .R7          (R7),
        .imm_in      (imm_in),
        .ExtOp       (ExtOp),
        .ExtPlace    (ExtPlace),
        .ext_out     (ext_out),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .gt          (gt),
        .lt          (lt),
        .eq          (eq)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    function automatic int to_signed16(input logic [15:0] v);
        int x;
        x = int'(v);
        if (x >= 32768) x = x - 65536;
        return x;
    endfunction

    // Compare every output against the model for the inputs currently applied
    task automatic checkAll(input string ctx);
        int imm, exp_ext, sa, sb;
        logic [15:0] exp_flags;
        imm = int'(imm_in);
        if (ExtPlace) exp_ext = imm * 256;
        else if (ExtOp && imm >= 128) exp_ext = imm + 65280;
        else exp_ext = imm;
        sa = to_signed16(cmp_a);
        sb = to_signed16(cmp_b);
        exp_flags = {13'd0, sa > sb, sa < sb, sa == sb};
        checkOutput({ctx, "/BusA"}, BusA, 16'(model_regs[RA]));
        checkOutput({ctx, "/BusB"}, BusB, 16'(model_regs[RB]));
        checkOutput({ctx, "/R7"}, R7, 16'(model_regs[7]));
        checkOutput({ctx, "/ext"}, ext_out, 16'(exp_ext));
        checkOutput({ctx, "/gt_lt_eq"}, {13'd0, gt, lt, eq}, exp_flags);
    endtask

    // Advance one clock edge, updating the model with what that edge should commit
    task automatic stepClock();
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) model_regs[i] = 0;
        end else if (enableWrite && RW != 3'd0) begin
            model_regs[RW] = int'(BusW);
        end
        @(posedge clk);
        #1;
    endtask

    // Random stimulus with extra weight on boundary compare values and equal operands
    task automatic applyStimulus();
        logic [15:0] edges [5];
        edges[0] = 16'h0000; edges[1] = 16'h7FFF; edges[2] = 16'h8000;
        edges[3] = 16'hFFFF; edges[4] = 16'h0001;
        rst_n       = ($urandom_range(0, 39) != 0);
        RA          = 3'($urandom_range(0, 7));
        RB          = 3'($urandom_range(0, 7));
        RW          = 3'($urandom_range(0, 7));
        enableWrite = ($urandom_range(0, 3) != 0);
        BusW        = 16'($urandom);
        imm_in      = 8'($urandom);
        ExtOp       = 1'($urandom);
        ExtPlace    = 1'($urandom);
        cmp_a       = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : 16'($urandom);
        case ($urandom_range(0, 5))
            0:       cmp_b = cmp_a;
            1:       cmp_b = edges[$urandom_range(0, 4)];
            default: cmp_b = 16'($urandom);
        endcase
        #1;
    endtask

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        for (int i = 0; i < 8; i++) model_regs[i] = 0;
        rst_n = 1'b0; RA = 3'd0; RB = 3'd0; RW = 3'd0; enableWrite = 1'b0;
        BusW = 16'h0; imm_in = 8'h0; ExtOp = 1'b0; ExtPlace = 1'b0;
        cmp_a = 16'h0; cmp_b = 16'h0;
        stepClock();
        rst_n = 1'b1;

        // All registers read zero after reset, on both ports
        for (int i = 0; i < 8; i++) begin
            RA = 3'(i); RB = 3'(7 - i); #1;
            checkAll("reset");
            checkOutput("reset_busa_zero", BusA, 16'h0000);
        end

        // Write R3: old value visible in the same cycle, new value afterwards
        RW = 3'd3; BusW = 16'hBEEF; enableWrite = 1'b1; RA = 3'd3; RB = 3'd3; #1;
        checkOutput("same_cycle_old", BusA, 16'h0000);
        stepClock();
        enableWrite = 1'b0; #1;
        checkOutput("r3_busa", BusA, 16'hBEEF);
        checkOutput("r3_busb", BusB, 16'hBEEF);

        // R0 ignores writes, R7 tap follows its register
        RW = 3'd0; BusW = 16'h1234; enableWrite = 1'b1; stepClock();
        RA = 3'd0; #1;
        checkOutput("r0_zero", BusA, 16'h0000);
        RW = 3'd7; BusW = 16'h00AA; stepClock();
        checkOutput("r7_tap", R7, 16'h00AA);

        // Disabled write leaves R2 untouched
        RW = 3'd2; BusW = 16'hFFFF; enableWrite = 1'b0; stepClock();
        RA = 3'd2; #1;
        checkOutput("r2_no_write", BusA, 16'h0000);

        // Mid-run reset clears everything, even with a write pending
        rst_n = 1'b0; RW = 3'd5; BusW = 16'h5555; enableWrite = 1'b1; stepClock();
        rst_n = 1'b1; enableWrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            RA = 3'(i); RB = 3'(i); #1;
            checkAll("midreset");
        end
        RA = 3'd3; #1;
        checkOutput("midreset_r3", BusA, 16'h0000);
        checkOutput("midreset_r7", R7, 16'h0000);

        // Extender corner cases
        imm_in = 8'h85; ExtOp = 1'b1; ExtPlace = 1'b0; #1;
        checkOutput("ext_sign", ext_out, 16'hFF85);
        ExtOp = 1'b0; #1;
        checkOutput("ext_zero", ext_out, 16'h0085);
        ExtPlace = 1'b1; #1;
        checkOutput("ext_high", ext_out, 16'h8500);
        ExtOp = 1'b1; #1;
        checkOutput("ext_high_sop", ext_out, 16'h8500);

        // Comparator corner cases, flags packed as {gt,lt,eq}
        cmp_a = 16'hFFFF; cmp_b = 16'h0001; #1;
        checkOutput("cmp_neg_lt", {13'd0, gt, lt, eq}, 16'h0002);
        cmp_a = 16'h7FFF; cmp_b = 16'h8000; #1;
        checkOutput("cmp_max_gt", {13'd0, gt, lt, eq}, 16'h0004);
        cmp_a = 16'h0042; cmp_b = 16'h0042; #1;
        checkOutput("cmp_eq", {13'd0, gt, lt, eq}, 16'h0001);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            applyStimulus();
            checkAll("rnd");
            stepClock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
